// File: rtl/acortex_i2c_pkg.sv
// Shared types and constants for the acortex I2C codec control-port model.
package acortex_i2c_pkg;

    localparam logic [6:0] SSM2603_DEV_ADDR = 7'h1A;
    localparam int         CODEC_DATA_W     = 9;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WB0, ACK0, WB1, ACK1, NACK_REST,
        RB0, RACK0, RB1, RACK1, WAIT_STOP
    } i2c_state_t;

    typedef struct packed {
        logic [6:0]              addr;
        logic [CODEC_DATA_W-1:0] data;
    } codec_word_t;

endpackage

// File: rtl/i2c_bus_cond.sv
// Brings SCL/SDA into the clk domain and derives edge and START/STOP strobes.
module i2c_bus_cond (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_i;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_i;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign sda      = sda_p1;
    assign scl_rise = scl_p1 & ~scl_p2;
    assign scl_fall = ~scl_p1 & scl_p2;
    assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_codec_slave.sv
// I2C responder modelling the SSM2603 control port: 16-bit register writes,
// two-byte read-back of the last addressed register, and a parallel read port.
module i2c_codec_slave
    import acortex_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SSM2603_DEV_ADDR,
    parameter int         NUM_REGS   = 16,
    localparam int        REG_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    output logic                    wr_evt,
    output logic [6:0]              wr_addr,
    output logic [CODEC_DATA_W-1:0] wr_data,
    input  logic [REG_ADDR_W-1:0]   reg_rd_addr,
    output logic [CODEC_DATA_W-1:0] reg_rd_data,
    output logic                    busy
);

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < NUM_REGS_B;
    endfunction

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_cond u_cond (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t              state;
    logic [7:0]              shreg;
    logic [2:0]              cnt;
    logic                    phase;
    logic                    rw;
    logic                    mack;
    logic [6:0]              last_addr;
    codec_word_t             word;
    logic [CODEC_DATA_W-1:0] regs [NUM_REGS];
    logic [CODEC_DATA_W-1:0] last_val;
    logic [7:0]              rb0, rb1;

    assign last_val    = in_range(last_addr) ? regs[last_addr[REG_ADDR_W-1:0]] : '0;
    assign rb0         = {last_addr, last_val[8]};
    assign rb1         = last_val[7:0];
    assign reg_rd_data = regs[reg_rd_addr];

    // ACK phases: first SCL fall drives/releases for the ack bit, second fall ends it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            phase     <= 1'b0;
            rw        <= 1'b0;
            mack      <= 1'b1;
            last_addr <= '0;
            word      <= '0;
            sda_oe    <= 1'b0;
            wr_evt    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_evt <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rw    <= sda_s;
                            phase <= 1'b0;
                            state <= (shreg[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                    ADDR_ACK, ACK0, ACK1: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            if (state == ADDR_ACK && rw) begin
                                state  <= RB0;
                                sda_oe <= ~rb0[7];
                                shreg  <= {rb0[6:0], 1'b0};
                            end else if (state == ADDR_ACK) begin
                                state <= WB0;
                            end else if (state == ACK0) begin
                                state <= WB1;
                            end else begin
                                state   <= NACK_REST;
                                wr_evt  <= 1'b1;
                                wr_addr <= word.addr;
                                wr_data <= word.data;
                                if (in_range(word.addr))
                                    regs[word.addr[REG_ADDR_W-1:0]] <= word.data;
                            end
                        end
                    end
                    WB0, WB1: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            phase <= 1'b0;
                            if (state == WB0) begin
                                word.addr    <= shreg[6:0];
                                word.data[8] <= sda_s;
                                last_addr    <= shreg[6:0];
                                state        <= ACK0;
                            end else begin
                                word.data[7:0] <= {shreg[6:0], sda_s};
                                state          <= ACK1;
                            end
                        end
                    end
                    RB0, RB1: begin
                        if (scl_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                phase <= 1'b0;
                                state <= (state == RB0) ? RACK0 : RACK1;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    RACK0, RACK1: begin
                        if (scl_rise && phase) begin
                            mack <= sda_s;
                        end else if (scl_fall && !phase) begin
                            sda_oe <= 1'b0;
                            phase  <= 1'b1;
                        end else if (scl_fall) begin
                            cnt <= '0;
                            if (mack) begin
                                state <= WAIT_STOP;
                            end else if (state == RACK0) begin
                                state  <= RB1;
                                sda_oe <= ~rb1[7];
                                shreg  <= {rb1[6:0], 1'b0};
                            end else begin
                                state  <= RB0;
                                sda_oe <= ~rb0[7];
                                shreg  <= {rb0[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed bench: bit-banged I2C master at SCL = clk/64 against the codec slave.
module tb_i2c_codec_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe, wr_evt, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, reg_rd_data;
    logic [3:0] reg_rd_addr = 4'd0;

    int         checks = 0;
    int         failures = 0;
    int         evt_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [6:0] cap_addr = '0;
    logic [8:0] cap_data = '0;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_slave dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .sda_oe      (sda_oe),
        .wr_evt      (wr_evt),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (wr_evt) begin
            evt_cnt++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic qtr();
        repeat (16) @(negedge clk);
    endtask

    task automatic bit_cell(input logic v, output logic s);
        qtr(); sda_m = v;
        qtr(); scl_m = 1'b1;
        qtr(); s = sda_i;
        qtr(); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        qtr(); sda_m = 1'b1;
        qtr(); scl_m = 1'b1;
        qtr(); sda_m = 1'b0;
        qtr(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        qtr(); sda_m = 1'b0;
        qtr(); scl_m = 1'b1;
        qtr(); sda_m = 1'b1;
        qtr();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cell(b[i], s);
        bit_cell(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack_v, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cell(1'b1, s);
            b[i] = s;
        end
        bit_cell(ack_v, s);
    endtask

    task automatic rd_reg(input logic [3:0] a, input string tag, input logic [8:0] exp);
        reg_rd_addr = a;
        @(negedge clk);
        check_val(tag, reg_rd_data, exp);
    endtask

    logic       ack, s;
    logic [7:0] rb;

    initial begin
        repeat (5) @(negedge clk);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_wr_evt", wr_evt, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_busy", busy, 0);
        rd_reg(4'd15, "rst_reg15", 9'h000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic register write.
        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack); check_val("wr_ack_dev", ack, 0);
        wr_byte(8'h1E, ack); check_val("wr_ack_b0", ack, 0);
        wr_byte(8'h05, ack); check_val("wr_ack_b1", ack, 0);
        check_val("wr_busy", busy, 1);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("wr_evt_cnt", evt_cnt, 1);
        check_val("wr_addr", cap_addr, 7'h0F);
        check_val("wr_data", cap_data, 9'h005);
        check_val("wr_busy_end", busy, 0);
        rd_reg(4'd15, "wr_reg15", 9'h005);

        // Device address mismatch.
        evt_cnt = 0;
        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h36, ack); check_val("mis_ack", ack, 1);
        check_val("mis_busy", busy, 1);
        wr_byte(8'h1E, ack);
        wr_byte(8'h07, ack);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("mis_oe_seen", oe_seen, 0);
        check_val("mis_evt_cnt", evt_cnt, 0);
        check_val("mis_busy_end", busy, 0);
        rd_reg(4'd15, "mis_reg15", 9'h005);

        // Write then repeated-START read-back.
        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack);
        wr_byte(8'h09, ack);
        wr_byte(8'hAB, ack); check_val("rb_wr_ack", ack, 0);
        i2c_start();
        wr_byte(8'h35, ack); check_val("rb_ack_dev", ack, 0);
        rd_byte(1'b0, rb); check_val("rb_byte0", rb, 8'h09);
        rd_byte(1'b1, rb); check_val("rb_byte1", rb, 8'hAB);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("rb_busy_end", busy, 0);
        check_val("rb_evt_cnt", evt_cnt, 1);
        check_val("rb_state_idle", 32'(dut.state), 0);
        rd_reg(4'd4, "rb_reg4", 9'h1AB);

        // Extra data byte after a full word is NACKed and dropped.
        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack); check_val("ex_ack_dev", ack, 0);
        wr_byte(8'h0C, ack); check_val("ex_ack_b0", ack, 0);
        wr_byte(8'h10, ack); check_val("ex_ack_b1", ack, 0);
        wr_byte(8'h55, ack); check_val("ex_nack_b2", ack, 1);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("ex_evt_cnt", evt_cnt, 1);
        rd_reg(4'd6, "ex_reg6", 9'h010);
        rd_reg(4'd4, "ex_reg4", 9'h1AB);

        // STOP in the middle of the first data byte.
        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack);
        for (int i = 0; i < 4; i++) bit_cell(1'b1, s);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("ab_stop_evt", evt_cnt, 0);
        check_val("ab_stop_busy", busy, 0);

        // Partial write sets the read address; reset while driving RB1.
        i2c_start();
        wr_byte(8'h34, ack);
        wr_byte(8'h0A, ack); check_val("ab_ack_b0", ack, 0);
        i2c_start();
        wr_byte(8'h35, ack);
        rd_byte(1'b0, rb); check_val("ab_rb0", rb, 8'h0A);
        for (int i = 0; i < 3; i++) bit_cell(1'b1, s);
        qtr();
        check_val("ab_oe_before", sda_oe, 1);
        check_val("ab_partial_evt", evt_cnt, 0);
        rst = 1'b1;
        #1;
        check_val("ab_oe_reset", sda_oe, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("ab_busy_after", busy, 0);
        rd_reg(4'd4, "ab_reg4_cleared", 9'h000);

        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack); check_val("ab_next_ack", ack, 0);
        wr_byte(8'h1A, ack);
        wr_byte(8'h77, ack); check_val("ab_next_ack_b1", ack, 0);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("ab_next_evt", evt_cnt, 1);
        check_val("ab_next_data", cap_data, 9'h077);
        rd_reg(4'd13, "ab_reg13", 9'h077);

        // Register address beyond the implemented range.
        evt_cnt = 0;
        i2c_start();
        wr_byte(8'h34, ack);
        wr_byte(8'h24, ack); check_val("oor_ack_b0", ack, 0);
        wr_byte(8'h5A, ack); check_val("oor_ack_b1", ack, 0);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("oor_evt", evt_cnt, 1);
        check_val("oor_addr", cap_addr, 7'h12);
        check_val("oor_data", cap_data, 9'h05A);
        rd_reg(4'd2, "oor_reg2", 9'h000);
        rd_reg(4'd13, "oor_reg13", 9'h077);
        i2c_start();
        wr_byte(8'h35, ack); check_val("oor_rd_ack", ack, 0);
        rd_byte(1'b0, rb); check_val("oor_rb0", rb, 8'h24);
        rd_byte(1'b1, rb); check_val("oor_rb1", rb, 8'h00);
        i2c_stop();
        repeat (8) @(negedge clk);
        check_val("oor_busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_codec_slave.md
Name: i2c_codec_slave

Overview:
- I2C responder that models the SSM2603 codec control port (7-bit device address, 16-bit register write words).
- Stands on the far end of the i2c_master bus inside acortex. Used as the codec register model in simulation and as an FPGA-side loopback target.
- Holds a small register file. Exposes each write as a pulse plus a parallel read port, so the ssm2603_drvr test flow can check programmed codec state.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit I2C device address the block responds to.
- NUM_REGS, 16, number of 9-bit codec registers implemented (addresses 0..NUM_REGS-1).
- REG_ADDR_W, $clog2(NUM_REGS), width of the register index (derived, not overridden).

Ports:
- clk  input  1  block clock; must run at least 8x SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL line sampled from the pad.
- sda_i  input  1  SDA line sampled from the pad.
- sda_oe  output  1  1 = pull SDA low (open drain). Never drives high.
- wr_evt  output  1  one-cycle pulse when a register write commits.
- wr_addr  output  7  codec register address of the committed write.
- wr_data  output  9  data of the committed write.
- reg_rd_addr  input  REG_ADDR_W  combinational register-file read index.
- reg_rd_data  output  9  register contents at reg_rd_addr.
- busy  output  1  high from detected START until detected STOP.

Behaviour:
- Reset values (asynchronous on rst): sda_oe=0, wr_evt=0, wr_addr=0, wr_data=0, busy=0. All registers are 0. FSM goes to IDLE.
- Input conditioning:
  - 2-flop synchronizer on scl_i and sda_i, plus one history flop.
  - Edge and START/STOP detection are therefore 3 clk late versus the pins.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - SDA is sampled on the SCL rise. sda_oe changes only on the SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WB0, ACK0, WB1, ACK1, NACK_REST, RB0, RACK0, RB1, RACK1, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR: shift in 8 bits, MSB first.
  - If [7:1]==DEV_ADDR, go to ADDR_ACK and drive sda_oe=1 for one SCL period.
  - Otherwise go to WAIT_STOP with no ACK.
  - Bit0=0 (write) goes next to WB0. Bit0=1 (read) goes next to RB0.
- WB0: byte = {addr[6:0], data[8]}; latch it, then ACK0.
- WB1: byte = data[7:0]; latch it, then ACK1.
  - At the SCL fall ending the ACK1 bit: write regs[addr], pulse wr_evt, update wr_addr/wr_data.
  - Then go to NACK_REST.
- NACK_REST: further data bytes are not ACKed and not stored. Stay here until STOP or repeated START.
- Register address >= NUM_REGS: the byte is still ACKed and wr_evt still fires, but the register file is unchanged.
- Read path:
  - RB0 shifts out {last_addr[6:0], reg[last_addr][8]}; RB1 shifts out reg[last_addr][7:0].
  - last_addr is the address from the most recent WB0 (0 after reset). Out-of-range addresses read as 0.
  - Each bit is set up on the SCL fall; sda_oe = ~bit.
  - RACK0/RACK1: release SDA and sample the master ACK. ACK after RB1 wraps to RB0; NACK goes to WAIT_STOP.
- Repeated START in any non-IDLE state goes to ADDR. A partial write (only WB0 seen) commits nothing but does update last_addr.
- STOP in any state goes to IDLE, clears sda_oe and clears busy. A STOP mid-byte discards the partial byte.
- Reset mid-transfer releases SDA immediately, regardless of SCL.
- Simultaneous reg_rd_addr read and a commit to the same register: reg_rd_data shows the old value that cycle and the new value the next cycle.

Decomposition:
- Package acortex_i2c_pkg holds:
  - the FSM state enum;
  - SSM2603_DEV_ADDR=7'h1A;
  - the codec register-word typedef (struct: addr[6:0], data[8:0]);
  - CODEC_DATA_W=9.
- One sub-module, i2c_bus_cond: synchronizers, SCL rise/fall strobes, START/STOP strobes.
- FSM, shifter and register file stay in the top.

Test Plan:
- Write: i2c_master writes 0x34,0x1E,0x05 (SCL = clk/64) -> three ACKs; wr_evt once with wr_addr=0x0F, wr_data=0x005; reg_rd_addr=15 gives 0x005.
- Address mismatch: device byte 0x36 -> no ACK (sda_oe stays 0 for the whole transfer), no wr_evt, busy falls on STOP.
- Read-back: write 0x34,0x09,0xAB, then repeated START 0x35 and read 2 bytes with master ACK then NACK -> bytes 0x09 and 0xAB returned, FSM in IDLE after STOP.
- Extra byte: 0x34,0x0C,0x10,0x55 -> ACK on the first three bytes, NACK on the 4th; regs[6]=0x010 only.
- Abort: STOP after WB0 bits 4 and reset asserted mid-RB1 -> no wr_evt; sda_oe=0 within 1 clk of reset; next transaction proceeds normally.
- Out-of-range: write addr 0x12 (NUM_REGS=16) -> ACKs and wr_evt with wr_addr=0x12; regs unchanged; read-back returns 0x24,0x00.
